// File: rtl/sha256_block_feeder.sv
// sha256_block_feeder: byte-serial message in, FIPS 180-4 padded single
// 512-bit block out to sha256_module, digest (or error) out on a
// valid/ready port. Messages of 1-55 bytes are hashed; longer ones are
// drained and reported as errors without starting the core.
//
// Optional build feature: define SHA_DOUBLE_HASH_EN to run a second pass
// over the first digest (SHA256d). Without it only a single pass exists.
module sha256_block_feeder #(
  parameter int TIMEOUT_CYCLES = 128,
  parameter int CNT_W          = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  input  logic         in_last,
  output logic         sha_start,
  output logic [511:0] sha_data_in,
  input  logic         sha_done,
  input  logic [255:0] sha_data_out,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] dig_data,
  output logic         dig_err,
  output logic         busy
);

  localparam logic [3:0] ST_COLLECT = 4'd0;
  localparam logic [3:0] ST_PAD     = 4'd1;
  localparam logic [3:0] ST_START   = 4'd2;
  localparam logic [3:0] ST_WAIT    = 4'd3;
  localparam logic [3:0] ST_DRAIN   = 4'd4;
  localparam logic [3:0] ST_OUT     = 4'd5;
`ifdef SHA_DOUBLE_HASH_EN
  localparam logic [3:0] ST_PAD2    = 4'd6;
  localparam logic [3:0] ST_START2  = 4'd7;
  localparam logic [3:0] ST_WAIT2   = 4'd8;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] MAX_BYTES = CNT_W'(55);
  localparam logic [CNT_W-1:0] TMO_LIM   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [511:0]     BLK_ZERO  = 512'd0;
  localparam logic [255:0]     DIG_ZERO  = 256'd0;

  // Bit position of message byte k: word k/4, big-endian within the word.
  function automatic logic [8:0] byte_lsb(input logic [5:0] k);
    byte_lsb = {k[5:2], 5'b00000} + {4'b0000, (2'd3 - k[1:0]), 3'b000};
  endfunction

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [511:0]     blk_q, blk_d;
  logic             start_q, start_d;
  logic             dvalid_q, dvalid_d;
  logic [255:0]     ddata_q, ddata_d;
  logic             derr_q, derr_d;

  logic             in_ready_s;
  logic             byte_acc_s;
  logic [CNT_W-1:0] cnt_nx_s;
  logic [CNT_W-1:0] tmo_nx_s;
  logic             tmo_hit_s;
  logic [31:0]      bitlen_s;

  assign in_ready_s = (state_q == ST_COLLECT) || (state_q == ST_DRAIN);
  assign byte_acc_s = in_valid & in_ready_s;
  assign cnt_nx_s   = cnt_q + CNT_ONE;
  assign tmo_nx_s   = tmo_q + CNT_ONE;
  assign tmo_hit_s  = (tmo_nx_s == TMO_LIM);
  assign bitlen_s   = {{(32-CNT_W-3){1'b0}}, cnt_nx_s, 3'b000};

  // Next-state logic: byte collection, padding, core handshake, result hold.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    blk_d    = blk_q;
    start_d  = 1'b0;
    dvalid_d = dvalid_q;
    ddata_d  = ddata_q;
    derr_d   = derr_q;
    case (state_q)
      ST_COLLECT: begin
        if (byte_acc_s) begin
          if (cnt_q < MAX_BYTES) begin
            blk_d[byte_lsb(cnt_q[5:0]) +: 8] = in_byte;
            cnt_d = cnt_nx_s;
            if (in_last) begin
              // The padding byte and bit length are written together with the
              // last byte so the block is already complete while in PAD.
              blk_d[byte_lsb(cnt_nx_s[5:0]) +: 8] = 8'h80;
              blk_d[511:480] = bitlen_s;
              state_d = ST_PAD;
            end else begin
              state_d = ST_COLLECT;
            end
          end else if (in_last) begin
            // 56th byte is also the last: oversize, report at once.
            state_d  = ST_OUT;
            dvalid_d = 1'b1;
            ddata_d  = DIG_ZERO;
            derr_d   = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_PAD: begin
        state_d = ST_START;
        start_d = 1'b1;
      end
      ST_START: begin
        state_d = ST_WAIT;
        tmo_d   = CNT_ZERO;
      end
      ST_WAIT: begin
        if (sha_done) begin
`ifdef SHA_DOUBLE_HASH_EN
          // Second block: first digest, 0x80 marker, zeros, 256-bit length.
          blk_d   = {32'h0000_0100, 192'd0, 32'h8000_0000, sha_data_out};
          tmo_d   = CNT_ZERO;
          state_d = ST_PAD2;
`else
          state_d  = ST_OUT;
          dvalid_d = 1'b1;
          ddata_d  = sha_data_out;
          derr_d   = 1'b0;
`endif
        end else if (tmo_hit_s) begin
          state_d  = ST_OUT;
          dvalid_d = 1'b1;
          ddata_d  = DIG_ZERO;
          derr_d   = 1'b1;
        end else begin
          tmo_d = tmo_nx_s;
        end
      end
`ifdef SHA_DOUBLE_HASH_EN
      ST_PAD2: begin
        state_d = ST_START2;
        start_d = 1'b1;
      end
      ST_START2: begin
        state_d = ST_WAIT2;
        tmo_d   = CNT_ZERO;
      end
      ST_WAIT2: begin
        if (sha_done) begin
          state_d  = ST_OUT;
          dvalid_d = 1'b1;
          ddata_d  = sha_data_out;
          derr_d   = 1'b0;
        end else if (tmo_hit_s) begin
          state_d  = ST_OUT;
          dvalid_d = 1'b1;
          ddata_d  = DIG_ZERO;
          derr_d   = 1'b1;
        end else begin
          tmo_d = tmo_nx_s;
        end
      end
`endif
      ST_DRAIN: begin
        if (byte_acc_s && in_last) begin
          state_d  = ST_OUT;
          dvalid_d = 1'b1;
          ddata_d  = DIG_ZERO;
          derr_d   = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_OUT: begin
        if (dig_ready) begin
          state_d  = ST_COLLECT;
          dvalid_d = 1'b0;
          ddata_d  = DIG_ZERO;
          derr_d   = 1'b0;
          blk_d    = BLK_ZERO;
          cnt_d    = CNT_ZERO;
          tmo_d    = CNT_ZERO;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d  = ST_COLLECT;
        dvalid_d = 1'b0;
        ddata_d  = DIG_ZERO;
        derr_d   = 1'b0;
        blk_d    = BLK_ZERO;
        cnt_d    = CNT_ZERO;
        tmo_d    = CNT_ZERO;
      end
    endcase
  end

  // State and output registers; reset aborts any pass in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_COLLECT;
      cnt_q    <= CNT_ZERO;
      tmo_q    <= CNT_ZERO;
      blk_q    <= BLK_ZERO;
      start_q  <= 1'b0;
      dvalid_q <= 1'b0;
      ddata_q  <= DIG_ZERO;
      derr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      blk_q    <= blk_d;
      start_q  <= start_d;
      dvalid_q <= dvalid_d;
      ddata_q  <= ddata_d;
      derr_q   <= derr_d;
    end
  end

  assign in_ready    = in_ready_s;
  assign sha_start   = start_q;
  assign sha_data_in = blk_q;
  assign dig_valid   = dvalid_q;
  assign dig_data    = ddata_q;
  assign dig_err     = derr_q;
  assign busy        = (state_q != ST_COLLECT);

endmodule

// File: tb/tb_sha256_block_feeder.sv
// Bench for sha256_block_feeder: table vectors, random messages, timeout
// and reset corner cases. A SHA-256 core model answers sha_start.
module tb_sha256_block_feeder;

  localparam int TMO = 128;
  localparam logic [255:0] ABC_DIG =
    256'hf20015ad_b410ff61_96177a9c_b00361a3_5dae2223_414140de_8f01cfea_ba7816bf;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef struct {
    string        txt;      // literal message, or "" for a generated one
    int           rlen;     // generated length: byte i = i*7+1
    int           hold;     // cycles dig_ready stays low
    bit           err;
    bit           chk_w;
    logic [31:0]  w0;
    logic [31:0]  w15;
    bit           chk_dig;
    logic [255:0] dig;
  } vec_t;

  logic         clk, reset_n, in_valid, in_ready, in_last;
  logic [7:0]   in_byte;
  logic         sha_start, sha_done, dig_valid, dig_ready, dig_err, busy;
  logic [511:0] sha_data_in;
  logic [255:0] sha_data_out, dig_data;

  int n_chk, n_pass, cyc, core_lat, done_cyc;
  bit core_en;
  logic [7:0]   msg [$];
  int           start_cyc [$];
  logic [511:0] start_blk [$];
  vec_t         vecs [6];

  sha256_block_feeder #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_byte(in_byte), .in_last(in_last), .sha_start(sha_start),
    .sha_data_in(sha_data_in), .sha_done(sha_done), .sha_data_out(sha_data_out),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
    .dig_err(dig_err), .busy(busy));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Plain single-block SHA-256 compression from the standard IV.
  function automatic logic [255:0] sha_compress(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] h [8];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    logic [255:0] r;
    h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int t = 0; t < 16; t++) w[t] = blk[32*t +: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = h[i];
    return r;
  endfunction

  // Standard padding of an n-byte message into one 64-byte block.
  function automatic logic [511:0] ref_pad(input logic [7:0] m [64], input int n);
    logic [7:0]  p [64];
    logic [31:0] bits;
    logic [511:0] r;
    for (int k = 0; k < 64; k++) p[k] = (k < n) ? m[k] : 8'h00;
    p[n] = 8'h80;
    bits = 32'(8 * n);
    p[60] = bits[31:24]; p[61] = bits[23:16]; p[62] = bits[15:8]; p[63] = bits[7:0];
    for (int j = 0; j < 16; j++) r[32*j +: 32] = {p[4*j], p[4*j+1], p[4*j+2], p[4*j+3]};
    return r;
  endfunction

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic chki(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // sha_start monitor: records cycle and block of every start pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (sha_start === 1'b1) begin
        start_cyc.push_back(cyc);
        start_blk.push_back(sha_data_in);
      end
    end
  end

  // Core model: digest of the started block, core_lat cycles later.
  initial begin
    logic [511:0] blk;
    forever begin
      @(negedge clk);
      if (sha_start === 1'b1 && core_en) begin
        blk = sha_data_in;
        repeat (core_lat) @(posedge clk);
        #1;
        sha_done = 1'b1;
        sha_data_out = sha_compress(blk);
        done_cyc = cyc;
        @(posedge clk);
        #1;
        sha_done = 1'b0;
      end
    end
  end

  // Sends msg with random idle gaps; t_last is the cycle the last byte moves.
  task automatic send_msg(output int t_last);
    bit acc;
    t_last = 0;
    for (int i = 0; i < msg.size(); i++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_byte  = msg[i];
      in_last  = (i == msg.size() - 1);
      acc = 1'b0;
      for (int w = 0; w < 50 && !acc; w++) begin
        @(negedge clk);
        if (in_ready) begin
          acc = 1'b1;
          t_last = cyc;
        end
        @(posedge clk); #1;
      end
      if (!acc) chki("byte_accept", 0, 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(output bit got, output int vcyc);
    got = 1'b0;
    vcyc = 0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      if (dig_valid) begin
        got = 1'b1;
        vcyc = cyc;
      end
    end
    chki("dig_valid_seen", int'(got), 1);
  endtask

  task automatic handoff();
    @(posedge clk); #1 dig_ready = 1'b1;
    @(posedge clk); #1 dig_ready = 1'b0;
    @(negedge clk);
    chki("handoff_in_ready", int'(in_ready), 1);
    chki("handoff_valid", int'(dig_valid), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_msg(input vec_t v);
    int t_last, vcyc;
    bit got, bad;
    logic [7:0] m [64];
    logic [511:0] eb, eb2;
    logic [255:0] d1, ed, hd;
    logic he;
    eb = '0; eb2 = '0; ed = '0; d1 = '0;
    for (int k = 0; k < 64; k++) m[k] = (k < msg.size()) ? msg[k] : 8'h00;
    if (!v.err) begin
      eb = ref_pad(m, msg.size());
      d1 = sha_compress(eb);
`ifdef SHA_DOUBLE_HASH_EN
      for (int i = 0; i < 8; i++)
        for (int b = 0; b < 4; b++) m[4*i+b] = d1[32*i + 24 - 8*b +: 8];
      eb2 = ref_pad(m, 32);
      ed = sha_compress(eb2);
`else
      ed = d1;
`endif
    end
    start_cyc.delete();
    start_blk.delete();
    send_msg(t_last);
    wait_valid(got, vcyc);
    if (!got) begin
      @(posedge clk); #1;
      return;
    end
    if (v.err) begin
      chki("err_starts", start_cyc.size(), 0);
      chki("err_flag", int'(dig_err), 1);
      chk("err_data", 512'(dig_data), 512'd0);
      chki("err_valid_lat", vcyc, t_last + 1);
    end else begin
`ifdef SHA_DOUBLE_HASH_EN
      chki("start_count", start_cyc.size(), 2);
`else
      chki("start_count", start_cyc.size(), 1);
`endif
      if (start_cyc.size() > 0) begin
        chki("start_lat", start_cyc[0], t_last + 2);
        chk("block", start_blk[0], eb);
        if (v.chk_w) begin
          chk("word0", 512'(start_blk[0][31:0]), 512'(v.w0));
          chk("word15", 512'(start_blk[0][511:480]), 512'(v.w15));
        end
`ifdef SHA_DOUBLE_HASH_EN
        if (start_cyc.size() > 1) begin
          chk("block2", start_blk[1], eb2);
          if (v.chk_dig) chk("block2_abc", 512'(start_blk[1][255:0]), 512'(v.dig));
        end
`endif
      end
      chk("digest", 512'(dig_data), 512'(ed));
      chki("dig_err", int'(dig_err), 0);
      chki("valid_lat", vcyc, done_cyc + 1);
`ifndef SHA_DOUBLE_HASH_EN
      if (v.chk_dig) chk("abc_digest", 512'(dig_data), 512'(v.dig));
`endif
    end
    hd = dig_data;
    he = dig_err;
    bad = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      if (dig_valid !== 1'b1 || dig_data !== hd || dig_err !== he || in_ready !== 1'b0 || busy !== 1'b1)
        bad = 1'b1;
    end
    if (v.hold > 0) chki("hold_stable", int'(bad), 0);
    handoff();
  endtask

  initial begin
    vec_t rv;
    int t_last, vcyc, len;
    bit got, bad;
    n_chk = 0; n_pass = 0;
    core_en = 1'b1; core_lat = 64; done_cyc = 0;
    reset_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00; in_last = 1'b0;
    dig_ready = 1'b0; sha_done = 1'b0; sha_data_out = '0;

    vecs[0] = '{"abc",        0,  0, 1'b0, 1'b1, 32'h61626380, 32'h00000018, 1'b1, ABC_DIG};
    vecs[1] = '{"1234567890", 0, 20, 1'b0, 1'b1, 32'h31323334, 32'h00000050, 1'b0, 256'd0};
    vecs[2] = '{"",          55,  0, 1'b0, 1'b1, 32'h01080f16, 32'h000001b8, 1'b0, 256'd0};
    vecs[3] = '{"",          56,  3, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 256'd0};
    vecs[4] = '{"",           1,  0, 1'b0, 1'b1, 32'h01800000, 32'h00000008, 1'b0, 256'd0};
    vecs[5] = '{"",          70,  0, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 256'd0};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chki("rst_start", int'(sha_start), 0);
    chk("rst_block", sha_data_in, 512'd0);
    chki("rst_valid", int'(dig_valid), 0);
    chk("rst_data", 512'(dig_data), 512'd0);
    chki("rst_err", int'(dig_err), 0);
    chki("rst_busy", int'(busy), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chki("rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      msg.delete();
      if (vecs[i].txt != "")
        for (int k = 0; k < vecs[i].txt.len(); k++) msg.push_back(vecs[i].txt[k]);
      else
        for (int k = 0; k < vecs[i].rlen; k++) msg.push_back(8'(k * 7 + 1));
      run_msg(vecs[i]);
    end

    // Core never answers: timeout after exactly TMO cycles in WAIT
    core_en = 1'b0;
    msg.delete();
    for (int k = 0; k < 5; k++) msg.push_back(8'($urandom));
    start_cyc.delete();
    start_blk.delete();
    send_msg(t_last);
    wait_valid(got, vcyc);
    chki("tmo_valid_lat", vcyc, t_last + 3 + TMO);
    chki("tmo_err", int'(dig_err), 1);
    chk("tmo_data", 512'(dig_data), 512'd0);
    chki("tmo_starts", start_cyc.size(), 1);
    handoff();

    // Reset in the middle of WAIT, then a stray sha_done
    msg.delete();
    for (int k = 0; k < 4; k++) msg.push_back(8'($urandom));
    send_msg(t_last);
    repeat (6) begin @(posedge clk); #1; end
    chki("mid_busy", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    chki("mid_rst_start", int'(sha_start), 0);
    chk("mid_rst_block", sha_data_in, 512'd0);
    chki("mid_rst_valid", int'(dig_valid), 0);
    chk("mid_rst_data", 512'(dig_data), 512'd0);
    chki("mid_rst_err", int'(dig_err), 0);
    chki("mid_rst_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    sha_done = 1'b1;
    sha_data_out = {8{$urandom}};
    @(posedge clk); #1 sha_done = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (dig_valid !== 1'b0 || busy !== 1'b0 || sha_start !== 1'b0) bad = 1'b1;
    end
    chki("late_done_ignored", int'(bad), 0);
    @(posedge clk); #1;
    core_en = 1'b1;
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    run_msg(vecs[0]);

    // Randomised messages
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 60);
      core_lat = $urandom_range(1, 20);
      msg.delete();
      for (int k = 0; k < len; k++) msg.push_back(8'($urandom));
      rv = '{"", len, $urandom_range(0, 3), (len > 55), 1'b0, 32'h0, 32'h0, 1'b0, 256'd0};
      run_msg(rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
